// File: rtl/npu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : npu_pkg
// Description : Shared NPU types and default sizing for the engine arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package npu_pkg;

   localparam int c_num_req_default = 4;
   localparam int c_timeout_default = 1024;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_CLEAR = 3'd1,
      ST_START = 3'd2,
      ST_WAIT  = 3'd3,
      ST_RESP  = 3'd4
   } state_t;

endpackage
`default_nettype wire

// File: rtl/conv_engine_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin pick: first set request at or after ptr.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter
   import npu_pkg::*;
#(
   parameter int NUM_REQ = c_num_req_default
) (
   input  logic [NUM_REQ-1:0]         req,
   input  logic [$clog2(NUM_REQ)-1:0] ptr,
   output logic [NUM_REQ-1:0]         grant,
   output logic [$clog2(NUM_REQ)-1:0] index,
   output logic                       any
);

   localparam int c_idx_w = $clog2(NUM_REQ);

   logic [c_idx_w:0]   w_sum;
   logic [c_idx_w-1:0] w_pos;

   // Scan from ptr upward with wraparound; the first hit wins.
   always_comb begin
      grant = '0;
      index = '0;
      any   = 1'b0;
      w_sum = '0;
      w_pos = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         w_sum = {1'b0, ptr} + (c_idx_w + 1)'(i);
         if (w_sum >= (c_idx_w + 1)'(NUM_REQ)) begin
            w_sum = w_sum - (c_idx_w + 1)'(NUM_REQ);
         end
         w_pos = w_sum[c_idx_w-1:0];
         if (!any && req[w_pos]) begin
            any          = 1'b1;
            grant[w_pos] = 1'b1;
            index        = w_pos;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/conv_engine_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : conv_engine_arbiter
// Description : Shares one convolution engine among NUM_REQ requesters with timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module conv_engine_arbiter
   import npu_pkg::*;
#(
   parameter int NUM_REQ = c_num_req_default,
   parameter int TIMEOUT = c_timeout_default
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_REQ-1:0]         req,
   output logic [NUM_REQ-1:0]         gnt,
   output logic [$clog2(NUM_REQ)-1:0] eng_sel,
   output logic                       eng_rst,
   output logic                       eng_start,
   input  logic                       eng_done,
   output logic [NUM_REQ-1:0]         rsp_valid,
   output logic                       rsp_error,
   output logic                       busy,
   output logic [7:0]                 err_count
);

   localparam int                 c_idx_w     = $clog2(NUM_REQ);
   localparam logic [15:0]        c_wait_last = 16'(TIMEOUT - 1);
   localparam logic [c_idx_w-1:0] c_last_idx  = c_idx_w'(NUM_REQ - 1);

   state_t               r_state;
   logic [NUM_REQ-1:0]   r_gnt;
   logic [c_idx_w-1:0]   r_sel;
   logic                 r_eng_rst;
   logic                 r_eng_start;
   logic [NUM_REQ-1:0]   r_rsp_valid;
   logic                 r_rsp_error;
   logic                 r_busy;
   logic [7:0]           r_err_count;
   logic [c_idx_w-1:0]   r_ptr;
   logic [15:0]          r_wait_cnt;
   logic                 r_done_q;

   logic [NUM_REQ-1:0]   w_arb_gnt;
   logic [c_idx_w-1:0]   w_arb_idx;
   logic                 w_arb_any;
   logic                 w_done_edge;
   logic                 w_timeout;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ)
   ) u_rr_arbiter (
      .req   (req),
      .ptr   (r_ptr),
      .grant (w_arb_gnt),
      .index (w_arb_idx),
      .any   (w_arb_any)
   );

   // Only a fresh 0->1 transition counts, so a done level left over from a
   // previous job cannot complete the current one.
   assign w_done_edge = eng_done & ~r_done_q;
   assign w_timeout   = (r_wait_cnt == c_wait_last);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_gnt       <= '0;
         r_sel       <= '0;
         r_eng_rst   <= 1'b1;
         r_eng_start <= 1'b0;
         r_rsp_valid <= '0;
         r_rsp_error <= 1'b0;
         r_busy      <= 1'b0;
         r_err_count <= '0;
         r_ptr       <= '0;
         r_wait_cnt  <= '0;
         r_done_q    <= 1'b0;
      end else begin
         r_done_q    <= eng_done;
         r_eng_rst   <= 1'b0;
         r_eng_start <= 1'b0;
         r_rsp_valid <= '0;
         r_rsp_error <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_arb_any) begin
                  r_gnt     <= w_arb_gnt;
                  r_sel     <= w_arb_idx;
                  r_ptr     <= (w_arb_idx == c_last_idx) ? '0 : w_arb_idx + c_idx_w'(1);
                  r_eng_rst <= 1'b1;
                  r_busy    <= 1'b1;
                  r_state   <= ST_CLEAR;
               end
            end
            ST_CLEAR: begin
               r_eng_start <= 1'b1;
               r_state     <= ST_START;
            end
            ST_START: begin
               r_wait_cnt <= '0;
               r_state    <= ST_WAIT;
            end
            ST_WAIT: begin
               // A done edge coinciding with the last wait cycle is a success.
               if (w_done_edge || w_timeout) begin
                  r_rsp_valid <= r_gnt;
                  r_rsp_error <= ~w_done_edge;
                  if (!w_done_edge && (r_err_count != 8'hFF)) begin
                     r_err_count <= r_err_count + 8'd1;
                  end
                  r_state <= ST_RESP;
               end else begin
                  r_wait_cnt <= r_wait_cnt + 16'd1;
               end
            end
            ST_RESP: begin
               r_gnt   <= '0;
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
            default: begin
               r_gnt   <= '0;
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign gnt       = r_gnt;
   assign eng_sel   = r_sel;
   assign eng_rst   = r_eng_rst;
   assign eng_start = r_eng_start;
   assign rsp_valid = r_rsp_valid;
   assign rsp_error = r_rsp_error;
   assign busy      = r_busy;
   assign err_count = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_conv_engine_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_conv_engine_arbiter
// Description : Directed self-checking bench for conv_engine_arbiter (4 req, TIMEOUT 32).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_conv_engine_arbiter;

   localparam int c_to = 32;

   logic       clk;
   logic       rst;
   logic [3:0] req;
   logic [3:0] gnt;
   logic [1:0] eng_sel;
   logic       eng_rst;
   logic       eng_start;
   logic       eng_done;
   logic [3:0] rsp_valid;
   logic       rsp_error;
   logic       busy;
   logic [7:0] err_count;

   int n_checks  = 0;
   int n_errors  = 0;
   int exp_errs  = 0;

   conv_engine_arbiter #(
      .NUM_REQ (4),
      .TIMEOUT (c_to)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .gnt       (gnt),
      .eng_sel   (eng_sel),
      .eng_rst   (eng_rst),
      .eng_start (eng_start),
      .eng_done  (eng_done),
      .rsp_valid (rsp_valid),
      .rsp_error (rsp_error),
      .busy      (busy),
      .err_count (err_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: observed=no_finish expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One complete job from IDLE; done_at is the WAIT cycle index where the
   // engine raises done (-1 = never). A stale engine holds done high and only
   // dips for one cycle before done_at.
   task automatic run_job(input logic [3:0] r, input int idx, input int done_at,
                          input bit stale, input bit drop);
      int  got;
      int  exp_lat;
      bit  exp_err;
      logic [3:0] oh;
      oh       = 4'b0001 << idx;
      exp_err  = !(done_at >= 0 && done_at <= c_to - 1);
      exp_lat  = exp_err ? c_to - 1 : done_at;
      got      = -1;
      req      = r;
      eng_done = stale;
      tick();
      chk("clear_gnt", gnt, oh);
      chk("clear_sel", eng_sel, idx);
      chk("clear_eng_rst", eng_rst, 1);
      chk("clear_eng_start", eng_start, 0);
      chk("clear_busy", busy, 1);
      tick();
      chk("start_eng_start", eng_start, 1);
      chk("start_eng_rst", eng_rst, 0);
      tick();
      for (int w = 0; w < c_to + 8; w++) begin
         eng_done = stale ? (w != done_at - 1) : (done_at >= 0 && w >= done_at);
         if (drop) req = '0;
         tick();
         if (rsp_valid != 0) begin
            got = w;
            break;
         end
      end
      if (exp_err && exp_errs < 255) exp_errs++;
      chk("resp_latency", got, exp_lat);
      chk("resp_valid", rsp_valid, oh);
      chk("resp_error", rsp_error, exp_err);
      chk("resp_gnt_hold", gnt, oh);
      chk("resp_err_count", err_count, exp_errs);
      eng_done = 1'b0;
      req      = '0;
      tick();
      chk("idle_gnt", gnt, 0);
      chk("idle_busy", busy, 0);
      chk("idle_rsp_valid", rsp_valid, 0);
      chk("idle_rsp_error", rsp_error, 0);
   endtask

   initial begin
      rst      = 1'b1;
      req      = '0;
      eng_done = 1'b0;
      tick();
      chk("rst_gnt", gnt, 0);
      chk("rst_sel", eng_sel, 0);
      chk("rst_eng_rst", eng_rst, 1);
      chk("rst_eng_start", eng_start, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_err_count", err_count, 0);
      rst = 1'b0;
      tick();
      chk("post_rst_eng_rst", eng_rst, 0);
      chk("post_rst_busy", busy, 0);

      // Fairness with all requesters active, 1-cycle engine
      for (int j = 0; j < 8; j++) run_job(4'b1111, j % 4, 0, 0, 0);

      // Sparse requests wrap around the pointer
      run_job(4'b1010, 1, 0, 0, 0);
      run_job(4'b1010, 3, 0, 0, 0);
      run_job(4'b1010, 1, 0, 0, 0);
      run_job(4'b0100, 2, 2, 0, 0);

      // Single job, engine done after 16 cycles
      run_job(4'b0001, 0, 15, 0, 0);

      // Requester withdraws during the job
      run_job(4'b1000, 3, 3, 0, 1);

      // Timeout, then done edge exactly on the last wait cycle
      run_job(4'b0100, 2, -1, 0, 0);
      run_job(4'b0010, 1, c_to - 1, 0, 0);

      // Stale done level: first never completes, second sees a fresh edge
      run_job(4'b0001, 0, -1, 1, 0);
      run_job(4'b0001, 0, 10, 1, 0);

      // Done activity while idle is ignored and the pointer holds
      for (int k = 0; k < 4; k++) begin
         eng_done = k[0];
         tick();
         chk("idle_done_busy", busy, 0);
         chk("idle_done_rsp", rsp_valid, 0);
      end
      eng_done = 1'b0;
      run_job(4'b1111, 1, 0, 0, 0);

      // Error counter saturation
      for (int k = 0; k < 300; k++) run_job(4'b0001, 0, -1, 0, 0);
      chk("err_count_sat", err_count, 255);

      // Reset in the middle of a job
      req = 4'b0100;
      tick();
      chk("mid_gnt", gnt, 4'b0100);
      chk("mid_sel", eng_sel, 2);
      tick();
      tick();
      rst = 1'b1;
      tick();
      chk("mrst_gnt", gnt, 0);
      chk("mrst_sel", eng_sel, 0);
      chk("mrst_eng_start", eng_start, 0);
      chk("mrst_rsp_valid", rsp_valid, 0);
      chk("mrst_rsp_error", rsp_error, 0);
      chk("mrst_busy", busy, 0);
      chk("mrst_err_count", err_count, 0);
      chk("mrst_eng_rst", eng_rst, 1);
      rst      = 1'b0;
      req      = '0;
      eng_done = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("mrst_after_rsp", rsp_valid, 0);
         chk("mrst_after_busy", busy, 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/conv_engine_arbiter.md
CONV_ENGINE_ARBITER -- requirements
Module: conv_engine_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, meaning the number of requesters sharing one convolution engine (2..8).
REQ-002 The block SHALL have parameter TIMEOUT, default 1024, meaning the maximum WAIT cycles before a job is aborted.
REQ-003 The block SHALL use one clock; reset is synchronous and active-high.
REQ-004 Port list:
clk  input  1  clock; all logic on rising edge
rst  input  1  synchronous active-high reset
req  input  NUM_REQ  per-requester job request (level)
gnt  output  NUM_REQ  one-hot owner of the engine; all zero when idle
eng_sel  output  $clog2(NUM_REQ)  index of owner; steers tile/kernel muxes and result demux
eng_rst  output  1  one-cycle active-high clear to the engine, which holds done until cleared
eng_start  output  1  one-cycle start pulse to the engine
eng_done  input  1  engine done level
rsp_valid  output  NUM_REQ  one-hot, one-cycle job-complete pulse to the owner
rsp_error  output  1  qualifies rsp_valid; 1 = job aborted by timeout
busy  output  1  high in every state except IDLE
err_count  output  8  saturating count of timeouts

Function
REQ-005 The FSM SHALL have states IDLE, CLEAR, START, WAIT, RESP, sequenced IDLE->CLEAR->START->WAIT->RESP->IDLE.
REQ-006 In IDLE with req != 0, the block SHALL select the winner round-robin from pointer ptr (first set bit at ptr, ptr+1, ... mod NUM_REQ), register gnt/eng_sel, and enter CLEAR next cycle.
REQ-007 After a grant to index k, ptr SHALL become (k+1) mod NUM_REQ; with req=0 ptr SHALL hold.
REQ-008 gnt and eng_sel SHALL stay constant from CLEAR through RESP; gnt SHALL be zero in IDLE.
REQ-009 eng_rst SHALL be 1 exactly in CLEAR; eng_start SHALL be 1 exactly in START.
REQ-010 In WAIT, a rising edge of eng_done (0 in previous cycle, 1 now) SHALL move to RESP with rsp_error=0; an eng_done level held high from before WAIT entry SHALL NOT count.
REQ-011 A 16-bit wait counter SHALL clear on WAIT entry and increment per WAIT cycle; reaching TIMEOUT-1 without a done edge SHALL move to RESP with rsp_error=1 and increment err_count, saturating at 255.
REQ-012 Done edge and timeout in the same cycle SHALL resolve as success (rsp_error=0).
REQ-013 In RESP, rsp_valid SHALL equal gnt for that one cycle; rsp_error SHALL be 0 outside RESP.
REQ-014 Deasserting req during a job SHALL NOT abort it; the response SHALL still be delivered.
REQ-015 The earliest new grant SHALL be registered in the cycle after RESP (no back-to-back overlap); minimum job turnaround is 5 cycles with a 1-cycle engine.
REQ-016 eng_done outside WAIT SHALL be ignored.

Reset
REQ-017 With rst=1 at a clock edge, the block SHALL enter IDLE and clear gnt, eng_sel, eng_start, rsp_valid, rsp_error, busy, err_count, ptr, the wait counter and the done-edge register to 0, and drive eng_rst=1 for that cycle.
REQ-018 Reset mid-job SHALL drop the job silently: no rsp_valid, err_count unchanged from 0.

Structure
REQ-019 The FSM state enum, default NUM_REQ and TIMEOUT SHALL live in shared package npu_pkg.
REQ-020 Round-robin selection SHALL be a combinational sub-module rr_arbiter (inputs req, ptr; outputs one-hot grant, index, any).

Verification
REQ-021 Single job: req=0001, engine done after 16 cycles -> gnt=0001 at cycle 1, eng_rst cycle 1, eng_start cycle 2, rsp_valid=0001 at the cycle after the done edge, rsp_error=0.
REQ-022 Fairness: req=1111 held for 8 jobs -> grant order 0,1,2,3,0,1,2,3.
REQ-023 Timeout: TIMEOUT=32, eng_done never rises -> rsp_valid with rsp_error=1 exactly 32 WAIT cycles after entry, err_count=1; 300 timeouts -> err_count=255.
REQ-024 Stale done: eng_done forced high before START -> no completion until timeout; a fresh 0->1 edge in WAIT completes normally.
REQ-025 Withdrawal and reset: req drops in WAIT -> response still delivered; rst=1 in WAIT -> next cycle all outputs 0, IDLE, no rsp_valid.
